ram_master: RTL and testbench

Bus initiator for the team's synchronous single-port RAM (10-bit address, 8-bit bidirectional data, active-high cs/rd/wr, sampled on posedge clk). It accepts single read/write requests from a client over a valid/ready handshake and drives the RAM bus. It returns read data, or a write acknowledge, as a one-cycle response pulse. It sits between any datapath client and the RAM, and owns the shared data bus direction.

---
 rtl/ram_master_pkg.sv | 15 +
 rtl/ram_master.sv | 110 +++++++++++
 tb/tb_ram_master.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_master_pkg.sv
// Shared types and constants for the ram_master bus initiator.
// Defining RAM_MASTER_VERIFY_EN adds the write read-back states.
package ram_master_pkg;

  localparam int RAM_AW     = 10;
  localparam int RAM_DW     = 8;
  localparam int RAM_RD_LAT = 1;

`ifdef RAM_MASTER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, VFY_ADDR, VFY_DATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;
`endif

endpackage

// File: rtl/ram_master.sv
// Single-request initiator for the synchronous single-port RAM; owns the data bus direction.
// Optional write read-back check is enabled with RAM_MASTER_VERIFY_EN.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] addr,
  inout  wire  [DW-1:0] data,
  output logic          cs,
  output logic          rd,
  output logic          wr
);

  state_t        state;
  logic [DW-1:0] wdata_q;

  assign req_ready = (state == IDLE) && !rst;

  // Only the WR state drives the bus, so it can never overlap a RAM read.
  assign data = (state == WR) ? wdata_q : {DW{1'bz}};

`ifdef RAM_MASTER_VERIFY_EN
  logic rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Bus strobes are set on the edge that enters each state, so they follow the state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cs        <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef RAM_MASTER_VERIFY_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr    <= req_addr;
            wdata_q <= req_wdata;
            cs      <= 1'b1;
            if (req_wr) begin
              state <= WR;
              wr    <= 1'b1;
            end else begin
              state <= RD_ADDR;
              rd    <= 1'b1;
            end
          end
        end
        WR: begin
          wr <= 1'b0;
`ifdef RAM_MASTER_VERIFY_EN
          state <= VFY_ADDR;
          rd    <= 1'b1;
`else
          state     <= IDLE;
          cs        <= 1'b0;
          rsp_valid <= 1'b1;
`endif
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          state     <= IDLE;
          cs        <= 1'b0;
          rd        <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= data;
`ifdef RAM_MASTER_VERIFY_EN
          rsp_err_q <= 1'b0;
`endif
        end
`ifdef RAM_MASTER_VERIFY_EN
        VFY_ADDR: state <= VFY_DATA;
        VFY_DATA: begin
          state     <= IDLE;
          cs        <= 1'b0;
          rd        <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= data;
          rsp_err_q <= (data != wdata_q);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Directed self-checking bench for ram_master with a behavioural synchronous RAM on the bus.
module tb_ram_master;
  import ram_master_pkg::*;

  localparam int RD_LAT = RAM_RD_LAT + 1;
`ifdef RAM_MASTER_VERIFY_EN
  localparam int  WR_LAT = 3;
  localparam logic VFY  = 1'b1;
`else
  localparam int  WR_LAT = 1;
  localparam logic VFY  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [9:0] addr;
  wire  [7:0] data;
  logic       cs;
  logic       rd;
  logic       wr;

  int errors = 0;
  int checks = 0;

  ram_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .addr      (addr),
    .data      (data),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr)
  );

  always #5 clk = ~clk;

  // RAM model: registered read with one cycle latency; corrupt flips bit 0 of written data.
  logic [7:0] mem [1024];
  logic [7:0] ram_dout;
  logic       ram_oe;
  logic       corrupt;

  assign data = ram_oe ? ram_dout : 8'hzz;

  always @(posedge clk) begin
    if (cs && wr) mem[addr] <= corrupt ? (data ^ 8'h01) : data;
    if (cs && rd) ram_dout <= mem[addr];
    ram_oe <= cs && rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One complete transaction from an idle block, checking bus phase and response timing.
  task automatic applyStimulus(input logic is_wr, input logic [9:0] a, input logic [7:0] d,
                               input logic chk_rdata, input logic [7:0] exp_rdata,
                               input logic exp_err);
    int lat;
    lat = is_wr ? WR_LAT : RD_LAT;
    req_valid = 1'b1;
    req_wr    = is_wr;
    req_addr  = a;
    req_wdata = d;
    checkOutput("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    checkOutput("cs_e0", cs, 1);
    checkOutput("wr_e0", wr, is_wr);
    checkOutput("rd_e0", rd, !is_wr);
    checkOutput("addr_e0", addr, a);
    checkOutput("req_ready_busy", req_ready, 0);
    if (is_wr) checkOutput("data_e0", data, d);
    for (int k = 1; k <= lat; k++) begin
      tick();
      checkOutput((k == lat) ? "rsp_valid_at_lat" : "rsp_valid_early", rsp_valid, k == lat);
    end
    if (chk_rdata) checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("rsp_err", rsp_err, exp_err);
    checkOutput("cs_after", cs, 0);
    checkOutput("rd_after", rd, 0);
    checkOutput("wr_after", wr, 0);
    tick();
    checkOutput("rsp_valid_end", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    ram_dout  = 8'h00;
    ram_oe    = 1'b0;
    corrupt   = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    tick();
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_cs", cs, 0);
    checkOutput("rst_rd", rd, 0);
    checkOutput("rst_wr", wr, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    tick();

    applyStimulus(1'b1, 10'h005, 8'hA5, VFY, 8'hA5, 1'b0);
    applyStimulus(1'b0, 10'h005, 8'h00, 1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b1, 10'h2AA, 8'h3C, VFY, 8'h3C, 1'b0);
    applyStimulus(1'b0, 10'h005, 8'h00, 1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 10'h2AA, 8'h00, 1'b1, 8'h3C, 1'b0);
    applyStimulus(1'b0, 10'h123, 8'h00, 1'b1, 8'h00, 1'b0);

    // Back-to-back with req_valid held: read waits for req_ready to return.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 10'h3FF;
    req_wdata = 8'h11;
    tick();
    req_wr    = 1'b0;
    req_wdata = 8'hEE;
    checkOutput("b2b_wr_strobe", wr, 1);
    checkOutput("b2b_data", data, 8'h11);
    n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    checkOutput("b2b_ready_return", n, WR_LAT);
    checkOutput("b2b_wr_rsp", rsp_valid, 1);
    tick();
    req_valid = 1'b0;
    checkOutput("b2b_rd_strobe", rd, 1);
    checkOutput("b2b_rd_addr", addr, 10'h3FF);
    checkOutput("b2b_rd_rsp_early", rsp_valid, 0);
    tick();
    checkOutput("b2b_rd_rsp_early2", rsp_valid, 0);
    tick();
    checkOutput("b2b_rd_rsp", rsp_valid, 1);
    checkOutput("b2b_rdata", rsp_rdata, 8'h11);
    tick();

    // Reset while in RD_ADDR drops the read.
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 10'h005;
    tick();
    req_valid = 1'b0;
    checkOutput("mid_rd_active", rd, 1);
    rst = 1'b1;
    tick();
    checkOutput("mid_cs", cs, 0);
    checkOutput("mid_rd", rd, 0);
    checkOutput("mid_ready_in_rst", req_ready, 0);
    checkOutput("mid_rsp_valid", rsp_valid, 0);
    checkOutput("mid_rdata_cleared", rsp_rdata, 0);
    rst = 1'b0;
    #1;
    checkOutput("mid_ready_after", req_ready, 1);
    tick();
    checkOutput("mid_no_rsp1", rsp_valid, 0);
    tick();
    checkOutput("mid_no_rsp2", rsp_valid, 0);

    // Faulty RAM write: bit 0 flipped in the array.
    corrupt = 1'b1;
    applyStimulus(1'b1, 10'h010, 8'h5A, VFY, 8'h5B, VFY);
    corrupt = 1'b0;
    applyStimulus(1'b0, 10'h010, 8'h00, 1'b1, 8'h5B, 1'b0);
    applyStimulus(1'b1, 10'h010, 8'h5A, VFY, 8'h5A, 1'b0);
    applyStimulus(1'b0, 10'h010, 8'h00, 1'b1, 8'h5A, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
